// File: rtl/vga_timing_gen_param_if.sv
// Timing bundle between the VGA timing engine and the pixel fetch pipeline.
// Latency: n/a (wires only). Backpressure: none; en is the only upstream control.
// The consumer drives en; the engine drives the counters, strobes and syncs.
interface vga_timing_gen_param_if #(
    parameter int H_W         = 10,
    parameter int V_W         = 10,
    parameter int FRAME_CNT_W = 8
);
    logic                   en;
    logic [H_W-1:0]         hcount;
    logic [V_W-1:0]         vcount;
    logic                   pixel_enable;
    logic                   tick;
    logic                   line_start;
    logic                   frame_start;
    logic                   vga_hs;
    logic                   vga_vs;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  en,
        output hcount, vcount, pixel_enable, tick, line_start, frame_start,
               vga_hs, vga_vs, frame_cnt
    );

    modport slave (
        output en,
        input  hcount, vcount, pixel_enable, tick, line_start, frame_start,
               vga_hs, vga_vs, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing engine: clock divider, h/v counters, sync decode, frame counter.
// Latency: counters registered; syncs/strobes decoded combinationally from them (0 extra cycles).
// Backpressure: en=0 freezes divider and counters; strobes drop, decoded outputs hold.
module vga_timing_gen_param #(
    parameter int CLK_FACTOR  = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    vga_timing_gen_param_if.master tif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    // Sync windows are stored as inclusive last positions so they always fit the counter width.
    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic           HS_LVL   = (HS_POL != 0);
    localparam logic           VS_LVL   = (VS_POL != 0);

    if (CLK_FACTOR < 1 || H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_cfg
        $error("vga_timing_gen_param: CLK_FACTOR, H_SYNC, V_SYNC, H_ACTIVE, V_ACTIVE must all be >= 1");
    end

    logic tick;

    if (CLK_FACTOR == 1) begin : g_nodiv
        assign tick = tif.en;
    end else begin : g_div
        localparam int                DIV_W    = $clog2(CLK_FACTOR);
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FACTOR - 1);

        logic [DIV_W-1:0] div_cnt;

        // Phase is kept across en=0 so a paused engine resumes mid-pixel.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                div_cnt <= '0;
            end else if (tif.en) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            end
        end

        assign tick = tif.en && (div_cnt == DIV_LAST);
    end

    logic [H_W-1:0]         hcount;
    logic [V_W-1:0]         vcount;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
        end else if (tick) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                if (vcount == V_LAST) begin
                    vcount    <= '0;
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                end else begin
                    vcount <= vcount + V_W'(1);
                end
            end else begin
                hcount <= hcount + H_W'(1);
            end
        end
    end

    logic hs_act;
    logic vs_act;

    assign hs_act = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    assign vs_act = (vcount >= VS_FIRST) && (vcount <= VS_LAST);

    assign tif.hcount       = hcount;
    assign tif.vcount       = vcount;
    assign tif.frame_cnt    = frame_cnt;
    assign tif.pixel_enable = (hcount < H_ACT) && (vcount < V_ACT);
    assign tif.tick         = tick;
    assign tif.line_start   = tick && (hcount == '0);
    assign tif.frame_start  = tick && (hcount == '0) && (vcount == '0);
    assign tif.vga_hs       = hs_act ? HS_LVL : ~HS_LVL;
    assign tif.vga_vs       = vs_act ? VS_LVL : ~VS_LVL;
endmodule
